multicycle_step_sequencer: RTL
==============================

Name: multicycle_step_sequencer

Overview:
- Parametrised successor to the per-signal step decoders of the multicycle RISC controller.
- One block owns the step counter (Cnt), decodes the latched instruction class, and generates MEMresource, Buff_PC, IR_load and Mem_write.
- New relative to the previous generation: a memory-ready wait handshake, a wait timeout, a halt state and illegal-opcode detection.
- Sits between the instruction register/memory interface and the datapath control signals.

Parameters:
- CNT_W, 3, width of the step counter Cnt; must be at least 3.
- USE_MEM_READY, 1, 1 = memory steps stall on mem_ready; 0 = mem_ready is ignored and treated as 1.
- WAIT_MAX, 15, maximum stall cycles in one memory step before timeout; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- InsM  in  5  instruction bits [15:11]; sampled only at the end of step 0.
- InsL  in  2  instruction bits [1:0]; sampled with InsM.
- mem_ready  in  1  memory access complete in the current cycle.
- Cnt  out  CNT_W  current step within the instruction.
- MEMresource  out  1  memory address select: 0 = PC (fetch), 1 = datapath address (LDR/STR data step).
- Mem_write  out  1  memory write strobe, STR data step only.
- IR_load  out  1  instruction register load, step 0 only, qualified by mem_ready.
- Buff_PC  out  1  last step of the instruction; PC buffer update; Cnt returns to 0 next.
- Halted  out  1  sticky; HLT retired.
- Ill_op  out  1  one-cycle pulse at step 1 for an undefined opcode.
- Mem_err  out  1  sticky; memory wait timeout.

Behaviour:
- Reset (Rst=0, asynchronous): state RUN, Cnt=0, latched op=0, wait counter=0. All outputs 0 except the combinational step-0 values once Rst=1. Assertion mid-instruction aborts immediately.
- FSM states: RUN, WAIT, HALT, ERR.
- RUN step 0 (fetch): MEMresource=0. A memory step completes on mem_ready=1 (always, if USE_MEM_READY=0).
  - On completion: IR_load=1, InsM/InsL latched, Cnt to 1.
  - Otherwise: enter WAIT, Cnt held.
- Instruction classes and last step L (decoded from the latched op):
  - ALU: InsM=00000 any InsL; LHI 00001; LLI 00010; ADDI 00111; SUBI 01000; MOV 01011; CMP = 00110 with InsL=01. L=3.
  - LDR: 00011, or 00100 with InsL=00. Data step 3. L=4.
  - STR: 00101, or 00110 with InsL=00. Data step 3. L=3.
  - BR: 11000 Bcond, 11001 BAL, 10000 JMP, 10011 JR. L=2.
  - JAL: 10001, 10010. L=3.
  - OUT: 11100 with InsL=00. L=2.
  - HLT: 11100 with InsL=01. L=2.
  - Anything else is ILL: Ill_op pulse at step 1, then executes as NOP with L=2.
- Data step (step 3 of LDR/STR): MEMresource=1; Mem_write=1 for STR. Stalls on mem_ready exactly as step 0.
- WAIT:
  - Outputs hold the values of the stalled step. Wait counter increments each cycle.
  - mem_ready=1: return to RUN and advance as RUN would have (IR_load/latch at step 0). Wait counter cleared.
  - Wait counter reaches WAIT_MAX with mem_ready still 0: enter ERR, Mem_err=1.
- Buff_PC=1 combinationally when Cnt==L in RUN. The next edge sets Cnt=0.
  - Buff_PC never asserts while in WAIT.
  - A Buff_PC on a data step is qualified by mem_ready.
- HLT: at its Buff_PC edge, enter HALT. Halted=1, Cnt=0, all strobes 0 until reset.
- ERR: Cnt frozen, all strobes 0, Mem_err=1 until reset.
- Cnt always wraps through 0 only via Buff_PC; it never exceeds 4.
- Simultaneous mem_ready and wait-counter==WAIT_MAX: mem_ready wins.

Decomposition:
- Package seq_pkg holds:
  - 5-bit opcode and 2-bit InsL constants for all 25 instructions.
  - Class enum: ALU, LDR, STR, BR, JAL, OUT, HLT, ILL.
  - Per-class last-step constants.
  - FSM state enum.
- Sub-module seq_class_decode: purely combinational; {InsM, InsL} -> class and Ill_op flag.

Test Plan:
- Rst low 2 cycles, then high; ADD (InsM=00000, InsL=00), mem_ready=1 -> Cnt sequence 0,1,2,3,0; Buff_PC only at Cnt=3; IR_load only at Cnt=0.
- LDRrr (00100/00) with mem_ready low 3 cycles at step 3 -> Cnt held at 3 for 4 cycles; MEMresource=1 throughout; Buff_PC at step 4.
- STRri (00101), mem_ready=1 -> Mem_write=1 and MEMresource=1 only at Cnt=3; Buff_PC also at Cnt=3.
- Sweep all 25 opcodes back-to-back -> cycle count per instruction = L+1; BEQ (11000) gives 3 cycles, JALrr gives 4 cycles.
- Undefined InsM=01111 -> Ill_op 1-cycle pulse at Cnt=1; Buff_PC at Cnt=2.
- mem_ready held 0 at step 0 with WAIT_MAX=15 -> Mem_err=1 after 15 stall cycles and stays 1.
- HLT (11100/01) -> Halted=1 after Cnt=2; no further IR_load.
- Rst pulsed low mid-WAIT -> immediate return to Cnt=0 with Mem_err=0.

Source files
------------

// File: rtl/multicycle_step_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_pkg: opcodes, instruction classes, last steps and FSM states      |
// | for the multicycle step sequencer.                                    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package seq_pkg;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_LDR, CLS_STR, CLS_BR, CLS_JAL, CLS_OUT, CLS_HLT, CLS_ILL
    } class_t;

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT, ST_ERR} state_t;

    // Each constant packs {InsM[4:0], InsL[1:0]}.
    localparam logic [6:0] c_ins_add   = 7'b00000_00;
    localparam logic [6:0] c_ins_adc   = 7'b00000_01;
    localparam logic [6:0] c_ins_sub   = 7'b00000_10;
    localparam logic [6:0] c_ins_sbc   = 7'b00000_11;
    localparam logic [6:0] c_ins_lhi   = 7'b00001_00;
    localparam logic [6:0] c_ins_lli   = 7'b00010_00;
    localparam logic [6:0] c_ins_ldrri = 7'b00011_00;
    localparam logic [6:0] c_ins_ldrrr = 7'b00100_00;
    localparam logic [6:0] c_ins_strri = 7'b00101_00;
    localparam logic [6:0] c_ins_strrr = 7'b00110_00;
    localparam logic [6:0] c_ins_cmp   = 7'b00110_01;
    localparam logic [6:0] c_ins_addi  = 7'b00111_00;
    localparam logic [6:0] c_ins_subi  = 7'b01000_00;
    localparam logic [6:0] c_ins_mov   = 7'b01011_00;
    localparam logic [6:0] c_ins_jmp   = 7'b10000_00;
    localparam logic [6:0] c_ins_jalri = 7'b10001_00;
    localparam logic [6:0] c_ins_jalrr = 7'b10010_00;
    localparam logic [6:0] c_ins_jr    = 7'b10011_00;
    localparam logic [6:0] c_ins_beq   = 7'b11000_00;
    localparam logic [6:0] c_ins_bne   = 7'b11000_01;
    localparam logic [6:0] c_ins_bcs   = 7'b11000_10;
    localparam logic [6:0] c_ins_bcc   = 7'b11000_11;
    localparam logic [6:0] c_ins_bal   = 7'b11001_00;
    localparam logic [6:0] c_ins_out   = 7'b11100_00;
    localparam logic [6:0] c_ins_hlt   = 7'b11100_01;

    localparam logic [2:0] c_last_alu = 3'd3;
    localparam logic [2:0] c_last_ldr = 3'd4;
    localparam logic [2:0] c_last_str = 3'd3;
    localparam logic [2:0] c_last_br  = 3'd2;
    localparam logic [2:0] c_last_jal = 3'd3;
    localparam logic [2:0] c_last_out = 3'd2;
    localparam logic [2:0] c_last_hlt = 3'd2;
    localparam logic [2:0] c_last_ill = 3'd2;
    localparam logic [2:0] c_data_step = 3'd3;

    function automatic logic [2:0] last_step(input class_t c);
        case (c)
            CLS_ALU: return c_last_alu;
            CLS_LDR: return c_last_ldr;
            CLS_STR: return c_last_str;
            CLS_BR:  return c_last_br;
            CLS_JAL: return c_last_jal;
            CLS_OUT: return c_last_out;
            CLS_HLT: return c_last_hlt;
            default: return c_last_ill;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_step_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_step_sequencer_if: instruction/memory inputs and step      |
// | control outputs of the sequencer.                                     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface multicycle_step_sequencer_if #(
    parameter int CNT_W = 3
);
    logic [4:0]       InsM;
    logic [1:0]       InsL;
    logic             mem_ready;
    logic [CNT_W-1:0] Cnt;
    logic             MEMresource;
    logic             Mem_write;
    logic             IR_load;
    logic             Buff_PC;
    logic             Halted;
    logic             Ill_op;
    logic             Mem_err;

    modport master (
        output InsM, InsL, mem_ready,
        input  Cnt, MEMresource, Mem_write, IR_load, Buff_PC, Halted, Ill_op, Mem_err
    );

    modport slave (
        input  InsM, InsL, mem_ready,
        output Cnt, MEMresource, Mem_write, IR_load, Buff_PC, Halted, Ill_op, Mem_err
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_step_sequencer_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_class_decode: combinational {InsM, InsL} -> instruction class     |
// | and illegal-opcode flag.                                              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seq_class_decode
    import seq_pkg::*;
(
    input  wire logic [4:0] i_ins_m,
    input  wire logic [1:0] i_ins_l,
    output class_t          o_class,
    output logic            o_ill
);
    always_comb begin
        o_class = CLS_ILL;
        case (i_ins_m)
            c_ins_add[6:2], c_ins_lhi[6:2], c_ins_lli[6:2],
            c_ins_addi[6:2], c_ins_subi[6:2], c_ins_mov[6:2]:
                o_class = CLS_ALU;
            c_ins_ldrri[6:2]: o_class = CLS_LDR;
            c_ins_ldrrr[6:2]: if (i_ins_l == c_ins_ldrrr[1:0]) o_class = CLS_LDR;
            c_ins_strri[6:2]: o_class = CLS_STR;
            // STRrr and CMP share an opcode and are split by InsL.
            c_ins_strrr[6:2]: begin
                if (i_ins_l == c_ins_strrr[1:0])     o_class = CLS_STR;
                else if (i_ins_l == c_ins_cmp[1:0])  o_class = CLS_ALU;
            end
            c_ins_beq[6:2], c_ins_bal[6:2], c_ins_jmp[6:2], c_ins_jr[6:2]:
                o_class = CLS_BR;
            c_ins_jalri[6:2], c_ins_jalrr[6:2]: o_class = CLS_JAL;
            c_ins_out[6:2]: begin
                if (i_ins_l == c_ins_out[1:0])       o_class = CLS_OUT;
                else if (i_ins_l == c_ins_hlt[1:0])  o_class = CLS_HLT;
            end
            default: ;
        endcase
    end

    assign o_ill = (o_class == CLS_ILL);
endmodule
`default_nettype wire

// File: rtl/multicycle_step_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_step_sequencer: step counter, memory-wait handshake,       |
// | halt/timeout handling and step control strobes.                       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module multicycle_step_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W         = 3,
    parameter int USE_MEM_READY = 1,
    parameter int WAIT_MAX      = 15
) (
    input  wire logic                    clk,
    input  wire logic                    Rst,
    multicycle_step_sequencer_if.slave   bus
);
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_op;
    logic [7:0]       r_wait;

    class_t           w_class;
    logic             w_ill;
    logic             w_rdy;
    logic             w_active;
    logic             w_data_step;
    logic             w_mem_step;
    logic             w_at_last;
    logic [7:0]       w_wait_next;
    logic [CNT_W-1:0] w_cnt_adv;

    seq_class_decode u_decode (
        .i_ins_m (r_op[6:2]),
        .i_ins_l (r_op[1:0]),
        .o_class (w_class),
        .o_ill   (w_ill)
    );

    generate
        if (USE_MEM_READY != 0) begin : g_rdy_used
            assign w_rdy = bus.mem_ready;
        end else begin : g_rdy_ignored
            assign w_rdy = 1'b1;
        end
    endgenerate

    assign w_active    = (r_state == ST_RUN) || (r_state == ST_WAIT);
    assign w_data_step = (r_cnt == CNT_W'(c_data_step)) &&
                         ((w_class == CLS_LDR) || (w_class == CLS_STR));
    assign w_mem_step  = (r_cnt == '0) || w_data_step;
    assign w_at_last   = (r_cnt == CNT_W'(last_step(w_class)));
    // The stall count includes the RUN cycle that first saw mem_ready low.
    assign w_wait_next = ((r_state == ST_WAIT) ? r_wait : 8'd0) + 8'd1;
    assign w_cnt_adv   = w_at_last ? '0 : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_op    <= '0;
            r_wait  <= '0;
        end else begin
            case (r_state)
                ST_RUN, ST_WAIT: begin
                    if (w_mem_step && !w_rdy) begin
                        r_wait  <= w_wait_next;
                        r_state <= (w_wait_next == 8'(WAIT_MAX)) ? ST_ERR : ST_WAIT;
                    end else begin
                        r_wait <= '0;
                        r_cnt  <= w_cnt_adv;
                        if (r_cnt == '0)
                            r_op <= {bus.InsM, bus.InsL};
                        r_state <= ((r_state == ST_RUN) && w_at_last && (w_class == CLS_HLT))
                                   ? ST_HALT : ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Cnt         = r_cnt;
    // Gated by Rst so no strobe appears while reset is held.
    assign bus.IR_load     = Rst && w_active && (r_cnt == '0) && w_rdy;
    assign bus.MEMresource = w_active && w_data_step;
    assign bus.Mem_write   = w_active && w_data_step && (w_class == CLS_STR);
    assign bus.Buff_PC     = (r_state == ST_RUN) && w_at_last && (!w_data_step || w_rdy);
    assign bus.Ill_op      = (r_state == ST_RUN) && (r_cnt == CNT_W'(1)) && w_ill;
    assign bus.Halted      = (r_state == ST_HALT);
    assign bus.Mem_err     = (r_state == ST_ERR);
endmodule
`default_nettype wire
